// File: rtl/pid_pkg.sv
// -----------------------------------------------------------------------------
// pid_pkg
// Shared definitions for the PID sequencer:
//   - pid_state_t : FSM state encoding (IDLE, ERR, MP, MI, MD, ACC, OUT)
//   - S16_MAX/MIN : 16-bit signed saturation limits
//   - DEFAULT_FRAC_BITS / DEFAULT_INT_W : default top-level parameter values
//   - sat17       : clamp a 17-bit signed difference into 16-bit signed range
// -----------------------------------------------------------------------------
package pid_pkg;

  localparam int DEFAULT_FRAC_BITS = 8;
  localparam int DEFAULT_INT_W     = 24;

  localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] S16_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_MP   = 3'd2,
    ST_MI   = 3'd3,
    ST_MD   = 3'd4,
    ST_ACC  = 3'd5,
    ST_OUT  = 3'd6
  } pid_state_t;

  // A 17-bit value fits in 16 bits exactly when its top two bits agree.
  function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
    logic signed [15:0] r;
    if (v[16] != v[15]) begin
      r = v[16] ? S16_MIN : S16_MAX;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_mult.sv
// -----------------------------------------------------------------------------
// pid_mult
// Signed A_W x B_W multiplier with one registered output stage.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset (clears the product register)
//   i_a     : signed A_W-bit operand
//   i_b     : signed B_W-bit operand
//   o_p     : signed (A_W+B_W)-bit product, valid one cycle after the operands
// -----------------------------------------------------------------------------
module pid_mult #(
  parameter int A_W = 16,
  parameter int B_W = 24
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic signed [A_W-1:0]      i_a,
  input  logic signed [B_W-1:0]      i_b,
  output logic signed [A_W+B_W-1:0]  o_p
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] r_p;
  logic        [P_W-1:0] w_a_ext;
  logic        [P_W-1:0] w_b_ext;

  // Sign-extend both operands to the full product width; the low P_W bits of
  // the product of the extended values equal the true signed product.
  assign w_a_ext = {{B_W{i_a[A_W-1]}}, i_a};
  assign w_b_ext = {{A_W{i_b[B_W-1]}}, i_b};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p <= '0;
    end else begin
      r_p <= w_a_ext * w_b_ext;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/pid_sequencer.sv
// -----------------------------------------------------------------------------
// pid_sequencer
// Sequential fixed-point PID controller built around one shared multiplier.
// Each accepted sample_tick walks IDLE->ERR->MP->MI->MD->ACC->OUT->IDLE,
// producing a saturated u with a one-cycle u_valid strobe 6 edges later.
//
// Ports:
//   clk_in      : clock, all state on the rising edge
//   reset       : synchronous active-low reset
//   en          : enable; ticks in IDLE are accepted only when high
//   sample_tick : one-cycle update request
//   setpoint    : signed 16-bit target
//   measured    : signed 16-bit plant feedback
//   kp, ki, kd  : signed 16-bit gains, FRAC_BITS fraction bits
//   clear_ovr   : clears the sticky overrun flag (a busy tick takes priority)
//   u           : signed saturated controller output, held between updates
//   u_valid     : one-cycle strobe marking a new u
//   busy        : high whenever the FSM is not in IDLE
//   overrun     : sticky, set by a tick that arrives while busy
//
// Build option: define PID_ANTIWINDUP_EN to freeze the integral on an update
// whose previous output saturated in the same direction as the new error.
// -----------------------------------------------------------------------------
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int INT_W     = DEFAULT_INT_W
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               en,
  input  logic               sample_tick,
  input  logic signed [15:0] setpoint,
  input  logic signed [15:0] measured,
  input  logic signed [15:0] kp,
  input  logic signed [15:0] ki,
  input  logic signed [15:0] kd,
  input  logic               clear_ovr,
  output logic signed [15:0] u,
  output logic               u_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int P_W   = 16 + INT_W;
  localparam int ACC_W = INT_W + 18;

  pid_state_t               r_state;
  logic signed [15:0]       r_sp, r_meas, r_kp, r_ki, r_kd;
  logic signed [15:0]       r_e, r_d, r_e_prev;
  logic signed [INT_W-1:0]  r_i;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [15:0]       r_u;
  logic                     r_u_valid;
  logic                     r_busy;
  logic                     r_overrun;

  logic signed [16:0]       w_e17, w_d17;
  logic signed [15:0]       w_e, w_d;
  logic signed [INT_W:0]    w_i_sum;
  logic signed [INT_W-1:0]  w_i_sat, w_i_new;
  logic signed [15:0]       w_mul_a;
  logic signed [INT_W-1:0]  w_mul_b;
  logic signed [P_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_sh;
  logic                     w_fits;
  logic signed [15:0]       w_u_sat;

  // ---------------- ERR-stage arithmetic ----------------
  assign w_e17 = {r_sp[15], r_sp} - {r_meas[15], r_meas};
  assign w_e   = sat17(w_e17);

  // Derivative uses the freshly saturated error, not the raw difference.
  assign w_d17 = {w_e[15], w_e} - {r_e_prev[15], r_e_prev};
  assign w_d   = sat17(w_d17);

  assign w_i_sum = {r_i[INT_W-1], r_i} + {{(INT_W-15){w_e[15]}}, w_e};
  assign w_i_sat = (w_i_sum[INT_W] != w_i_sum[INT_W-1])
                 ? (w_i_sum[INT_W] ? {1'b1, {(INT_W-1){1'b0}}}
                                   : {1'b0, {(INT_W-1){1'b1}}})
                 : w_i_sum[INT_W-1:0];

  // ---------------- OUT-stage scaling and clamp ----------------
  assign w_acc_sh = r_acc >>> FRAC_BITS;
  // Fits in 16 bits when every bit from 15 upward equals the sign.
  assign w_fits   = (&w_acc_sh[ACC_W-1:15]) | ~(|w_acc_sh[ACC_W-1:15]);
  assign w_u_sat  = w_fits ? w_acc_sh[15:0]
                           : (w_acc_sh[ACC_W-1] ? S16_MIN : S16_MAX);

`ifdef PID_ANTIWINDUP_EN
  logic r_sat_hi, r_sat_lo;
  logic w_freeze;

  assign w_freeze = (r_sat_hi && !w_e[15] && (w_e != '0)) || (r_sat_lo && w_e[15]);
  assign w_i_new  = w_freeze ? r_i : w_i_sat;

  // Direction of the most recent output saturation, captured in OUT.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else if (r_state == ST_OUT) begin
      r_sat_hi <= !w_fits && !w_acc_sh[ACC_W-1];
      r_sat_lo <= !w_fits &&  w_acc_sh[ACC_W-1];
    end
  end
`else
  assign w_i_new = w_i_sat;
`endif

  // ---------------- shared multiplier ----------------
  // Operands are steered by state; the product appears one state later.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      ST_MP: begin
        w_mul_a = r_kp;
        w_mul_b = {{(INT_W-16){r_e[15]}}, r_e};
      end
      ST_MI: begin
        w_mul_a = r_ki;
        w_mul_b = r_i;
      end
      ST_MD: begin
        w_mul_a = r_kd;
        w_mul_b = {{(INT_W-16){r_d[15]}}, r_d};
      end
      default: ;
    endcase
  end

  pid_mult #(
    .A_W (16),
    .B_W (INT_W)
  ) u_mult (
    .i_clk   (clk_in),
    .i_rst_n (reset),
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_p     (w_prod)
  );

  assign w_prod_ext = {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sp      <= '0;
      r_meas    <= '0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_kd      <= '0;
      r_e       <= '0;
      r_d       <= '0;
      r_e_prev  <= '0;
      r_i       <= '0;
      r_acc     <= '0;
      r_u       <= '0;
      r_u_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_u_valid <= 1'b0;

      // A tick while busy wins over a simultaneous clear.
      if (r_busy && sample_tick) begin
        r_overrun <= 1'b1;
      end else if (clear_ovr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (en && sample_tick) begin
            r_sp    <= setpoint;
            r_meas  <= measured;
            r_kp    <= kp;
            r_ki    <= ki;
            r_kd    <= kd;
            r_busy  <= 1'b1;
            r_state <= ST_ERR;
          end
        end
        ST_ERR: begin
          r_e     <= w_e;
          r_d     <= w_d;
          r_i     <= w_i_new;
          r_state <= ST_MP;
        end
        ST_MP: begin
          r_acc   <= '0;
          r_state <= ST_MI;
        end
        ST_MI: begin
          r_acc   <= r_acc + w_prod_ext;   // kp*e
          r_state <= ST_MD;
        end
        ST_MD: begin
          r_acc   <= r_acc + w_prod_ext;   // ki*I
          r_state <= ST_ACC;
        end
        ST_ACC: begin
          r_acc   <= r_acc + w_prod_ext;   // kd*d
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_u       <= w_u_sat;
          r_u_valid <= 1'b1;
          r_e_prev  <= r_e;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign u       = r_u;
  assign u_valid = r_u_valid;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_pid_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pid_sequencer
// Self-checking bench for pid_sequencer: a table of directed vectors, hand
// sequences for overrun / reset-abort / enable / saturation corners, and a
// randomized run compared against an arithmetic reference model.
// Follows PID_ANTIWINDUP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_pid_sequencer;

  localparam int FRAC_BITS = 8;
  localparam int INT_W     = 24;
  localparam longint IMAX  = (64'sd1 <<< (INT_W - 1)) - 1;
  localparam longint IMIN  = -(64'sd1 <<< (INT_W - 1));

  logic               clk;
  logic               reset;
  logic               en;
  logic               sample_tick;
  logic signed [15:0] setpoint, measured, kp, ki, kd;
  logic               clear_ovr;
  logic signed [15:0] u;
  logic               u_valid, busy, overrun;

  pid_sequencer #(
    .FRAC_BITS (FRAC_BITS),
    .INT_W     (INT_W)
  ) dut (
    .clk_in      (clk),
    .reset       (reset),
    .en          (en),
    .sample_tick (sample_tick),
    .setpoint    (setpoint),
    .measured    (measured),
    .kp          (kp),
    .ki          (ki),
    .kd          (kd),
    .clear_ovr   (clear_ovr),
    .u           (u),
    .u_valid     (u_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  longint m_i, m_eprev;
  bit     m_sat_hi, m_sat_lo;

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_i = 0; m_eprev = 0; m_sat_hi = 0; m_sat_lo = 0;
  endtask

  task automatic model_step(input int sp, input int meas, input int gp, input int gi,
                            input int gd, output int u_exp);
    longint e, inew, d, acc, q;
    e    = clamp(longint'(sp) - longint'(meas), -32768, 32767);
    inew = clamp(m_i + e, IMIN, IMAX);
`ifdef PID_ANTIWINDUP_EN
    if ((m_sat_hi && e > 0) || (m_sat_lo && e < 0)) inew = m_i;
`endif
    d    = clamp(e - m_eprev, -32768, 32767);
    acc  = longint'(gp) * e + longint'(gi) * inew + longint'(gd) * d;
    q    = acc >>> FRAC_BITS;
    u_exp    = int'(clamp(q, -32768, 32767));
    m_sat_hi = (q > 32767);
    m_sat_lo = (q < -32768);
    m_i      = inew;
    m_eprev  = e;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; sample_tick = 1'b0; clear_ovr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One full update: tick at edge 0, wait (bounded) for u_valid, confirm the
  // 6-edge latency and the single-cycle strobe width, return u.
  task automatic run_update(input int sp, input int meas, input int gp, input int gi,
                            input int gd, input bit drop_en, output int u_got);
    int lat;
    @(negedge clk);
    setpoint = 16'(sp); measured = 16'(meas);
    kp = 16'(gp); ki = 16'(gi); kd = 16'(gd);
    en = 1'b1; sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_tick = 1'b0;
    if (drop_en) en = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (u_valid) begin
        lat = n;
        break;
      end
    end
    u_got = int'(u);
    check("latency", lat, 6);
    @(posedge clk); #1;
    check("uvalid_width", int'(u_valid), 0);
    $display("txn sp=%0d meas=%0d kp=%0d ki=%0d kd=%0d -> u=%0d lat=%0d",
             sp, meas, gp, gi, gd, u_got, lat);
  endtask

  typedef struct {
    bit do_rst;
    int sp, meas, gp, gi, gd;
    int exp_u;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, cnt, u_exp, sp, meas, gp, gi, gd, gap;

    tbl[0]  = '{1, 1000, 400, 'h100, 0, 0, 600};
    tbl[1]  = '{0, 1000, 0, 'h7FFF, 0, 0, 32767};
    tbl[2]  = '{0, 0, 1000, 'h7FFF, 0, 0, -32768};
    tbl[3]  = '{1, 10, 0, 0, 'h100, 0, 10};
    tbl[4]  = '{0, 10, 0, 0, 'h100, 0, 20};
    tbl[5]  = '{0, 10, 0, 0, 'h100, 0, 30};
    tbl[6]  = '{1, 0, 0, 0, 0, 'h100, 0};
    tbl[7]  = '{0, 50, 0, 0, 0, 'h100, 50};
    tbl[8]  = '{1, 32767, -32768, 'h100, 0, 0, 32767};
    tbl[9]  = '{1, -32768, 32767, 'h100, 0, 0, -32768};
    tbl[10] = '{1, 32767, -32768, 0, 0, 'h100, 32767};
    tbl[11] = '{0, -32768, 32767, 0, 0, 'h100, -32768};
    tbl[12] = '{1, 0, 1, 'h80, 0, 0, -1};

    reset = 1'b0; en = 1'b0; sample_tick = 1'b0; clear_ovr = 1'b0;
    setpoint = '0; measured = '0; kp = '0; ki = '0; kd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_u", int'(u), 0);
    check("rst_u_valid", int'(u_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b1;
    model_reset();

    // ---------------- directed table ----------------
    for (int k = 0; k < NV; k++) begin
      if (tbl[k].do_rst) do_reset();
      run_update(tbl[k].sp, tbl[k].meas, tbl[k].gp, tbl[k].gi, tbl[k].gd, 1'b0, got);
      check($sformatf("vec%0d_u", k), got, tbl[k].exp_u);
    end

    // u holds between updates
    repeat (5) @(posedge clk);
    #1 check("u_hold", int'(u), -1);

    // ---------------- overrun ----------------
    do_reset();
    @(negedge clk);
    setpoint = 16'sd5; measured = '0; kp = 16'sh0100; ki = '0; kd = '0;
    en = 1'b1; sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_tick = 1'b0;
    @(posedge clk);
    @(negedge clk); sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_tick = 1'b0;
    check("busy_mid", int'(busy), 1);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (u_valid) cnt++;
    end
    check("ovr_one_valid", cnt, 1);
    check("ovr_set", int'(overrun), 1);
    check("busy_done", int'(busy), 0);
    @(negedge clk); clear_ovr = 1'b1;
    @(posedge clk);
    @(negedge clk); clear_ovr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    // tick + clear together while busy: set wins
    sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); clear_ovr = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_tick = 1'b0; clear_ovr = 1'b0;
    check("ovr_set_wins", int'(overrun), 1);
    repeat (10) @(posedge clk);
    #1 check("ovr_sticky", int'(overrun), 1);
    check("u_before_reset", int'(u), 5);
    do_reset();
    check("rst2_overrun", int'(overrun), 0);
    check("rst2_u", int'(u), 0);

    // ---------------- enable handling ----------------
    @(negedge clk);
    setpoint = 16'sd300; measured = 16'sd100; kp = 16'sh0100;
    en = 1'b0; sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_tick = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (u_valid || busy) cnt++;
    end
    check("en_low_ignored", cnt, 0);
    check("en_low_no_ovr", int'(overrun), 0);
    run_update(300, 100, 'h100, 0, 0, 1'b1, got);
    check("en_drop_u", got, 200);

    // ---------------- reset during MI ----------------
    do_reset();
    run_update(100, 0, 0, 'h100, 'h200, 1'b0, got);
    check("pre_abort_u", got, 300);
    @(negedge clk);
    en = 1'b1; sample_tick = 1'b1;
    @(posedge clk);
    @(negedge clk); sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_in_mi", int'(busy), 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    model_reset();
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (u_valid) cnt++;
    end
    check("abort_no_valid", cnt, 0);
    check("abort_u", int'(u), 0);
    check("abort_busy", int'(busy), 0);
    run_update(100, 0, 0, 'h100, 'h200, 1'b0, got);
    check("post_abort_u", got, 300);

    // ---------------- integral saturation / anti-windup ----------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_update(1000, 0, 'h7FFF, 'h100, 0, 1'b0, got);
      check("aw_sat_u", got, 32767);
    end
    run_update(0, 0, 0, 'h100, 0, 1'b0, got);
`ifdef PID_ANTIWINDUP_EN
    check("aw_probe_I", got, 1000);
`else
    check("aw_probe_I", got, 3000);
`endif

    do_reset();
    for (int k = 0; k < 260; k++) begin
      run_update(32767, -32768, 0, 1, 0, 1'b0, got);
      if (k == 0) check("int_first_u", got, 127);
    end
    check("int_limit_u", got, 32767);

    // ---------------- randomized vs model ----------------
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        sp   = int'($signed(16'($urandom)));
        meas = int'($signed(16'($urandom)));
      end else begin
        sp   = int'($urandom_range(0, 4000)) - 2000;
        meas = int'($urandom_range(0, 4000)) - 2000;
      end
      if ($urandom_range(0, 1) == 0) begin
        gp = int'($signed(16'($urandom)));
        gi = int'($signed(16'($urandom)));
        gd = int'($signed(16'($urandom)));
      end else begin
        gp = int'($urandom_range(0, 512));
        gi = int'($urandom_range(0, 64));
        gd = int'($urandom_range(0, 512));
      end
      model_step(sp, meas, gp, gi, gd, u_exp);
      run_update(sp, meas, gp, gi, gd, 1'b0, got);
      check($sformatf("rand%0d_u", k), got, u_exp);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pid_sequencer.md
PID_SEQUENCER -- requirements
Module: pid_sequencer

Interface
REQ-001 Parameter FRAC_BITS, default 8: fixed-point fraction bits of kp/ki/kd (0x0100 = 1.0).
REQ-002 Parameter INT_W, default 24: integral accumulator width, signed.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 en  input  1  controller enable; ticks are ignored while low.
REQ-006 sample_tick  input  1  one-cycle pulse requesting one PID update.
REQ-007 setpoint  input  16  signed target value.
REQ-008 measured  input  16  signed plant feedback.
REQ-009 kp, ki, kd  input  16 each  signed gains from the coefficient register memory.
REQ-010 clear_ovr  input  1  clears the overrun flag.
REQ-011 u  output  16  signed, saturated controller output.
REQ-012 u_valid  output  1  one-cycle strobe marking a new u.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-015 The FSM SHALL have states IDLE, ERR, MP, MI, MD, ACC and OUT, each lasting exactly one cycle, in that order; OUT returns to IDLE.
REQ-016 In IDLE with en=1 and sample_tick=1, the FSM SHALL latch setpoint, measured, kp, ki and kd, then go to ERR.
REQ-017 ERR SHALL compute e = setpoint - measured in 17 bits and saturate it to 16-bit signed.
REQ-018 ERR SHALL compute the new integral I = I_prev + e, saturated to INT_W-bit signed range.
REQ-019 ERR SHALL compute d = e - e_prev, saturated to 16-bit signed.
REQ-020 One shared signed multiplier (16 x INT_W, one-cycle registered) SHALL be used: MP issues kp*e, MI issues ki*I, MD issues kd*d.
REQ-021 A signed accumulator of INT_W+18 bits SHALL be cleared in MP and SHALL add each product as it emerges; the last add completes in ACC.
REQ-022 OUT SHALL compute acc >>> FRAC_BITS (arithmetic shift), saturate it to [-32768, 32767], register it to u and assert u_valid for exactly one cycle.
REQ-023 OUT SHALL also update e_prev with e.
REQ-024 Latency: u_valid SHALL assert 6 rising edges after the edge that samples sample_tick.
REQ-025 A sample_tick while busy=1 SHALL be ignored and SHALL set overrun.
REQ-026 If sample_tick and clear_ovr arrive in the same cycle while busy=1, overrun SHALL be set.
REQ-027 clear_ovr while not busy, or without a tick, SHALL clear overrun.
REQ-028 Deasserting en mid-computation SHALL NOT abort the update; the FSM SHALL complete through OUT.
REQ-029 While en=0, I and e_prev SHALL hold their values.
REQ-030 Between updates, u SHALL hold its last value.

Reset
REQ-031 With reset=0 at a clock edge, the block SHALL set: FSM=IDLE, u=0, u_valid=0, busy=0, overrun=0, I=0, e_prev=0, accumulator=0.
REQ-032 Reset asserted mid-computation SHALL abort the update with no u_valid pulse.

Configuration
REQ-033 With PID_ANTIWINDUP_EN defined, the integral SHALL be frozen (I = I_prev) in any update whose previous OUT saturated u in the same sign as e; a saturation flag register, reset to 0, records this.
REQ-034 Without PID_ANTIWINDUP_EN, the integral SHALL saturate only at its INT_W limits, and the flag logic SHALL be absent.

Structure
REQ-035 Package pid_pkg SHALL hold the FSM state enum, the saturation limit constants and the default FRAC_BITS/INT_W values.
REQ-036 The shared multiplier SHALL be a sub-module named pid_mult (signed, one-cycle registered, parameterised widths).

Verification
REQ-037 kp=0x0100, ki=kd=0, setpoint=1000, measured=400, one tick -> u=600 with u_valid exactly 6 edges after the tick.
REQ-038 kp=0x7FFF, e=1000 -> u=32767; measured=1000, setpoint=0 -> u=-32768.
REQ-039 ki=0x0100, kp=kd=0, e=10 on three ticks -> u=10, 20, 30.
REQ-040 kd=0x0100, kp=ki=0, e=0 then e=50 -> u=0, then u=50.
REQ-041 Second tick 2 cycles after the first -> one u_valid only and overrun=1; clear_ovr while idle -> overrun=0.
REQ-042 reset=0 during MI -> no u_valid, u=0; next update uses I=0 and e_prev=0 (with PID_ANTIWINDUP_EN: ki=0x0100, kp=0x7FFF saturating, I stays constant across ticks).
